// File: rtl/button_debounce_pkg.sv
// Shared types and timing constants for the push-button conditioning block.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    REL   = 2'b00,
    CHK_P = 2'b01,
    PRS   = 2'b10,
    CHK_R = 2'b11
  } db_state_e;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned CYC_20MS  = CLK_HZ / 50;
  localparam int unsigned CYC_500MS = CLK_HZ / 2;
  localparam int unsigned CYC_100MS = CLK_HZ / 10;

  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// Single-channel synchroniser + debounce FSM; repeat logic only when
// BUTTON_DEBOUNCE_AUTOREPEAT_EN is defined.
module button_debounce_ch
  import button_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = CYC_20MS,
  parameter int unsigned REPEAT_DELAY    = CYC_500MS,
  parameter int unsigned REPEAT_PERIOD   = CYC_100MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_db,
  output logic o_press,
  output logic o_release,
  output logic o_press_evt
);

  localparam int unsigned   CW      = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  db_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic          w_commit_p;
  logic          w_commit_r;
  logic          w_rpt_fire;

  assign w_commit_p = (r_state == CHK_P) && !r_sync2 && (r_cnt == DB_LAST);
  assign w_commit_r = (r_state == CHK_R) &&  r_sync2 && (r_cnt == DB_LAST);

`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  logic [CW-1:0] r_rpt;
  logic          r_rpt_first;

  assign w_rpt_fire = (r_state == PRS) && !r_sync2 &&
                      (r_rpt == (r_rpt_first ? RD_LAST : RP_LAST));

  // The first-interval flag survives a CHK_R bounce so the resumed count uses the same interval.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rpt       <= '0;
      r_rpt_first <= 1'b1;
    end else if ((r_state == PRS) && !r_sync2) begin
      if (w_rpt_fire) begin
        r_rpt       <= '0;
        r_rpt_first <= 1'b0;
      end else begin
        r_rpt <= r_rpt + 1'b1;
      end
    end else begin
      r_rpt <= '0;
      if (w_commit_r) r_rpt_first <= 1'b1;
    end
  end
`else
  assign w_rpt_fire = 1'b0;
`endif

  assign o_press_evt = w_commit_p || w_rpt_fire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= REL;
      r_cnt     <= '0;
      o_db      <= 1'b1;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      o_press   <= w_commit_p || w_rpt_fire;
      o_release <= w_commit_r;
      case (r_state)
        REL: begin
          if (!r_sync2) begin
            r_state <= CHK_P;
            r_cnt   <= '0;
          end
        end
        CHK_P: begin
          if (r_sync2) begin
            r_state <= REL;
            r_cnt   <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state <= PRS;
            r_cnt   <= '0;
            o_db    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRS: begin
          if (r_sync2) begin
            r_state <= CHK_R;
            r_cnt   <= '0;
          end
        end
        CHK_R: begin
          if (!r_sync2) begin
            r_state <= PRS;
            r_cnt   <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state <= REL;
            r_cnt   <= '0;
            o_db    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= REL;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_debounce.sv
// N-channel button debouncer with last-pressed latch. Optional auto-repeat:
// define BUTTON_DEBOUNCE_AUTOREPEAT_EN.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = CYC_20MS,
  parameter int unsigned REPEAT_DELAY    = CYC_500MS,
  parameter int unsigned REPEAT_PERIOD   = CYC_100MS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] buttons,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] last_btn
);

  logic [N_BTN-1:0] w_press_evt;
  logic [N_BTN-1:0] w_lowest;
  logic [N_BTN-1:0] r_last;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_btn      (buttons[g]),
      .o_db       (btn_db[g]),
      .o_press    (press_pulse[g]),
      .o_release  (release_pulse[g]),
      .o_press_evt(w_press_evt[g])
    );
  end

  // Isolating the lowest set bit gives lowest-index priority on simultaneous commits.
  assign w_lowest = w_press_evt & (~w_press_evt + 1'b1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= '1;
    end else if (|w_press_evt) begin
      r_last <= ~w_lowest;
    end
  end

  assign last_btn = r_last;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce with DEBOUNCE_CYCLES=4, REPEAT 10/3.
module tb_button_debounce;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  press;
    logic [3:0]  rel;
    logic [3:0]  db;
    logic [3:0]  last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] buttons;
  logic [3:0] btn_db;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] last_btn;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  exp_t        m_e;
  int unsigned e0, e1;

  button_debounce #(
    .N_BTN          (4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .buttons      (buttons),
    .btn_db       (btn_db),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .last_btn     (last_btn)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int unsigned c, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] d, input logic [3:0] l);
    exp_t e;
    e.cyc = c; e.press = p; e.rel = r; e.db = d; e.last = l;
    q.push_back(e);
  endtask

  task automatic nwait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every cycle showing a pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if ((press_pulse | release_pulse) !== 4'b0000) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: actual press=%b release=%b at cycle %0d, required none",
                 press_pulse, release_pulse, cyc);
      end else begin
        m_e = q.pop_front();
        chk("pulse_cycle",   cyc,           m_e.cyc);
        chk("press_pulse",   press_pulse,   m_e.press);
        chk("release_pulse", release_pulse, m_e.rel);
        chk("btn_db",        btn_db,        m_e.db);
        chk("last_btn",      last_btn,      m_e.last);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion before 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    buttons = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_btn_db",   btn_db,        4'b1111);
    chk("reset_press",    press_pulse,   4'b0000);
    chk("reset_release",  release_pulse, 4'b0000);
    chk("reset_last_btn", last_btn,      4'b1111);

    // Held through reset: re-debounced from REL
    rst_n = 1'b1;
    e0 = cyc + 1;
    expect_ev(e0 + 6, 4'b1111, 4'b0000, 4'b0000, 4'b1110);
    nwait(7);
    buttons = 4'b1111;
    e1 = cyc + 1;
    expect_ev(e1 + 6, 4'b0000, 4'b1111, 4'b1111, 4'b1110);
    nwait(8);

    // Clean press and release of button 2
    buttons = 4'b1011;
    e0 = cyc + 1;
    expect_ev(e0 + 6, 4'b0100, 4'b0000, 4'b1011, 4'b1011);
    nwait(8);
    chk("press_btn_db_held", btn_db,      4'b1011);
    chk("press_one_cycle",   press_pulse, 4'b0000);
    buttons = 4'b1111;
    e1 = cyc + 1;
    expect_ev(e1 + 6, 4'b0000, 4'b0100, 4'b1111, 4'b1011);
    nwait(8);
    chk("release_keeps_last", last_btn, 4'b1011);

    // Bounce on button 0: low 3, high 1, low 3, then high
    for (int i = 0; i < 7; i++) begin
      buttons = {3'b111, (i == 3) ? 1'b1 : 1'b0};
      nwait(1);
    end
    buttons = 4'b1111;
    nwait(10);
    chk("bounce_btn_db",   btn_db,   4'b1111);
    chk("bounce_last_btn", last_btn, 4'b1011);

    // Simultaneous press of buttons 1 and 3
    buttons = 4'b0101;
    e0 = cyc + 1;
    expect_ev(e0 + 6, 4'b1010, 4'b0000, 4'b0101, 4'b1101);
    nwait(8);
    buttons = 4'b1111;
    e1 = cyc + 1;
    expect_ev(e1 + 6, 4'b0000, 4'b1010, 4'b1111, 4'b1101);
    nwait(8);

    // Long hold of button 3
    buttons = 4'b0111;
    e0 = cyc + 1;
    expect_ev(e0 + 6, 4'b1000, 4'b0000, 4'b0111, 4'b0111);
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
    expect_ev(e0 + 16, 4'b1000, 4'b0000, 4'b0111, 4'b0111);
    expect_ev(e0 + 19, 4'b1000, 4'b0000, 4'b0111, 4'b0111);
    expect_ev(e0 + 22, 4'b1000, 4'b0000, 4'b0111, 4'b0111);
`endif
    nwait(22);
    buttons = 4'b1111;
    e1 = cyc + 1;
    expect_ev(e1 + 6, 4'b0000, 4'b1000, 4'b1111, 4'b0111);
    nwait(14);

    chk("pending_events", q.size(), 0);
    chk("final_btn_db",   btn_db,   4'b1111);
    chk("final_last_btn", last_btn, 4'b0111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
